decoder_cycle_sequencer: RTL and testbench

Front-end sequencer that feeds the opcode decoder tree. Runs opcode-fetch (M1) and memory-read (MR) machine cycles against the memory port and latches the fetched opcode. Drives the decoder with `Source`/`notSource`, the T-state counter `XPT`/`notXPT` and `enable`. Consumes the decoder's `PR_Reset_XPT`, `P2_Set_CM1` and `P2_Set_CMR` strobes to pick the next machine cycle.

---
 rtl/decoder_cycle_sequencer_if.sv | 10 +
 rtl/decoder_cycle_sequencer.sv | 149 ++++++++++++++
 tb/tb_decoder_cycle_sequencer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_cycle_sequencer_if.sv
// Memory port between decoder_cycle_sequencer (master) and the memory/bus side (slave).
interface decoder_cycle_sequencer_if;
    logic [7:0] Mem_Data;
    logic       Mem_Ready;
    logic       Mem_Req;
    logic       Mem_M1;

    modport master (input Mem_Data, input Mem_Ready, output Mem_Req, output Mem_M1);
    modport slave  (output Mem_Data, output Mem_Ready, input Mem_Req, input Mem_M1);
endinterface

// File: rtl/decoder_cycle_sequencer.sv
// Opcode-fetch / memory-read sequencer in front of the opcode decoder tree.
// Optional wait-state timeout is enabled with `define SEQ_WAIT_TIMEOUT_EN.
module decoder_cycle_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             notReset,
    decoder_cycle_sequencer_if.master        mem,
    input  logic                             PR_Reset_XPT,
    input  logic                             P2_Set_CM1,
    input  logic                             P2_Set_CMR,
    output logic                             enable,
    output logic [4:0]                       XPT,
    output logic [4:0]                       notXPT,
    output logic [7:0]                       Source,
    output logic [7:0]                       notSource,
    output logic [7:0]                       Operand,
    output logic                             Bus_Timeout
);

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        READ
    } state_t;

    state_t     state, state_d;
    logic       req_q, m1_q;
    logic [4:0] xpt_q, xpt_d, xpt_inc;
    logic [7:0] source_q, source_d;
    logic [7:0] operand_q, operand_d;
    logic       expired;
    logic       done;
    logic [7:0] rd_data;

    // A request completes on Mem_Ready or, with the timeout feature, on expiry
    // with an implied 8'h00 read value.
    assign done    = req_q && (mem.Mem_Ready || expired);
    assign rd_data = mem.Mem_Ready ? mem.Mem_Data : 8'h00;
    assign xpt_inc = (xpt_q == 5'd31) ? xpt_q : xpt_q + 5'd1;

    always_ff @(posedge clk) begin
        if (!notReset) begin
            state <= FETCH;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        xpt_d     = xpt_q;
        source_d  = source_q;
        operand_d = operand_q;
        case (state)
            FETCH: begin
                if (done) begin
                    source_d = rd_data;
                    xpt_d    = '0;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (P2_Set_CM1) begin
                    state_d = FETCH;
                    xpt_d   = xpt_inc;
                end else if (P2_Set_CMR) begin
                    // XPT holds on the cycle that launches a read; the read's
                    // completion supplies the single increment for that T-state.
                    state_d = READ;
                end else begin
                    xpt_d = xpt_inc;
                end
                if (PR_Reset_XPT) begin
                    xpt_d = '0;
                end
            end
            READ: begin
                if (done) begin
                    operand_d = rd_data;
                    xpt_d     = xpt_inc;
                    state_d   = EXEC;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Request qualifiers are registered from the next state so a strobe at
    // edge n presents the new request at n+1 with no bubble.
    always_ff @(posedge clk) begin
        if (!notReset) begin
            req_q     <= 1'b0;
            m1_q      <= 1'b0;
            xpt_q     <= '0;
            source_q  <= '0;
            operand_q <= '0;
        end else begin
            req_q     <= (state_d != EXEC);
            m1_q      <= (state_d == FETCH);
            xpt_q     <= xpt_d;
            source_q  <= source_d;
            operand_q <= operand_d;
        end
    end

`ifdef SEQ_WAIT_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_q;
    logic       timeout_q;

    assign expired = req_q && !mem.Mem_Ready && (wait_q == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (!notReset) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == EXEC || done) begin
                wait_q <= '0;
            end else if (req_q) begin
                wait_q <= wait_q + 8'd1;
            end
            if (expired) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign Bus_Timeout = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign expired            = 1'b0;
    assign Bus_Timeout        = 1'b0;
`endif

    assign mem.Mem_Req = req_q;
    assign mem.Mem_M1  = m1_q;
    assign enable      = (state == EXEC);
    assign XPT         = xpt_q;
    assign notXPT      = ~xpt_q;
    assign Source      = source_q;
    assign notSource   = ~source_q;
    assign Operand     = operand_q;

endmodule

// File: tb/tb_decoder_cycle_sequencer.sv
// Self-checking bench for decoder_cycle_sequencer: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_decoder_cycle_sequencer;

`ifdef SEQ_WAIT_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    logic       clk = 1'b0;
    logic       notReset = 1'b0;
    logic       PR_Reset_XPT = 1'b0;
    logic       P2_Set_CM1 = 1'b0;
    logic       P2_Set_CMR = 1'b0;
    logic       enable;
    logic [4:0] XPT, notXPT;
    logic [7:0] Source, notSource, Operand;
    logic       Bus_Timeout;

    decoder_cycle_sequencer_if mem ();

    decoder_cycle_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .notReset     (notReset),
        .mem          (mem),
        .PR_Reset_XPT (PR_Reset_XPT),
        .P2_Set_CM1   (P2_Set_CM1),
        .P2_Set_CMR   (P2_Set_CMR),
        .enable       (enable),
        .XPT          (XPT),
        .notXPT       (notXPT),
        .Source       (Source),
        .notSource    (notSource),
        .Operand      (Operand),
        .Bus_Timeout  (Bus_Timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: phase is 0 = fetching, 1 = executing, 2 = reading.
    int         m_phase = 0;
    bit         m_req = 0;
    bit         m_m1 = 0;
    int         m_xpt = 0;
    logic [7:0] m_src = 8'h00;
    logic [7:0] m_op = 8'h00;
    bit         m_to = 0;
    int         m_wait = 0;

    // Advance one clock: model computes the next values from the inputs
    // present before the edge, then outputs are sampled 1 time unit after it.
    task automatic tick();
        int         nph, nxpt, nwait;
        logic [7:0] nsrc, nop, data;
        bit         nto, done, tout;
        nph = m_phase; nxpt = m_xpt; nsrc = m_src; nop = m_op; nto = m_to; nwait = m_wait;
        if (!notReset) begin
            nph = 0; nxpt = 0; nsrc = 8'h00; nop = 8'h00; nto = 0; nwait = 0;
        end else begin
            tout = 0;
`ifdef SEQ_WAIT_TIMEOUT_EN
            tout = m_req && !mem.Mem_Ready && (m_wait + 1 >= int'(TO));
`endif
            done = m_req && (mem.Mem_Ready || tout);
            data = mem.Mem_Ready ? mem.Mem_Data : 8'h00;
            if (tout) nto = 1;
            if (m_phase == 1 || done) nwait = 0;
            else if (m_req) nwait = m_wait + 1;
            if (m_phase == 0) begin
                if (done) begin nsrc = data; nxpt = 0; nph = 1; end
            end else if (m_phase == 1) begin
                if (P2_Set_CM1) nph = 0;
                else if (P2_Set_CMR) nph = 2;
                if (!(P2_Set_CMR && !P2_Set_CM1)) nxpt = (m_xpt + 1 > 31) ? 31 : m_xpt + 1;
                if (PR_Reset_XPT) nxpt = 0;
            end else begin
                if (done) begin nop = data; nxpt = (m_xpt + 1 > 31) ? 31 : m_xpt + 1; nph = 1; end
            end
        end
        @(posedge clk);
        #1;
        m_phase = nph; m_xpt = nxpt; m_src = nsrc; m_op = nop; m_to = nto; m_wait = nwait;
        m_req = notReset && (nph != 1);
        m_m1  = notReset && (nph == 0);
    endtask

    task automatic test_reset();
        notReset = 1'b0;
        mem.Mem_Ready = 1'b1;
        mem.Mem_Data = 8'hA5;
        repeat (3) tick();
        checks++; if (XPT !== 5'd0 || notXPT !== 5'h1F) begin errors++; $display("FAIL reset_xpt: got %h/%h want 00/1f", XPT, notXPT); end
        checks++; if (Source !== 8'h00 || notSource !== 8'hFF) begin errors++; $display("FAIL reset_source: got %h/%h want 00/ff", Source, notSource); end
        checks++; if (Operand !== 8'h00 || Bus_Timeout !== 1'b0) begin errors++; $display("FAIL reset_operand_to: got %h/%b want 00/0", Operand, Bus_Timeout); end
        checks++; if (mem.Mem_Req !== 1'b0 || mem.Mem_M1 !== 1'b0 || enable !== 1'b0) begin errors++; $display("FAIL reset_ctrl: got req=%b m1=%b en=%b want 0/0/0", mem.Mem_Req, mem.Mem_M1, enable); end
        notReset = 1'b1;
        mem.Mem_Ready = 1'b0;
        tick();
        checks++; if (mem.Mem_Req !== 1'b1 || mem.Mem_M1 !== 1'b1 || enable !== 1'b0) begin errors++; $display("FAIL release_fetch: got req=%b m1=%b en=%b want 1/1/0", mem.Mem_Req, mem.Mem_M1, enable); end
    endtask

    task automatic test_zero_wait_count();
        mem.Mem_Ready = 1'b1;
        mem.Mem_Data = 8'h00;
        tick();
        mem.Mem_Ready = 1'b0;
        checks++; if (Source !== 8'h00 || notSource !== 8'hFF || enable !== 1'b1 || XPT !== 5'd0) begin errors++; $display("FAIL zw_fetch: got src=%h nsrc=%h en=%b xpt=%0d want 00/ff/1/0", Source, notSource, enable, XPT); end
        for (int i = 1; i <= 40; i++) begin
            tick();
            checks++; if (XPT !== 5'((i > 31) ? 31 : i) || notXPT !== ~XPT) begin errors++; $display("FAIL xpt_count: got %0d want %0d", XPT, (i > 31) ? 31 : i); end
        end
    endtask

    task automatic test_wait_fetch_read();
        P2_Set_CM1 = 1'b1;
        tick();
        P2_Set_CM1 = 1'b0;
        checks++; if (enable !== 1'b0 || mem.Mem_Req !== 1'b1 || mem.Mem_M1 !== 1'b1) begin errors++; $display("FAIL cm1_to_fetch: got en=%b req=%b m1=%b want 0/1/1", enable, mem.Mem_Req, mem.Mem_M1); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (mem.Mem_Req !== 1'b1 || mem.Mem_M1 !== 1'b1 || enable !== 1'b0) begin errors++; $display("FAIL fetch_wait: got req=%b m1=%b en=%b want 1/1/0", mem.Mem_Req, mem.Mem_M1, enable); end
        end
        mem.Mem_Ready = 1'b1;
        mem.Mem_Data = 8'h18;
        tick();
        mem.Mem_Ready = 1'b0;
        checks++; if (Source !== 8'h18 || enable !== 1'b1 || XPT !== 5'd0 || mem.Mem_Req !== 1'b0) begin errors++; $display("FAIL fetch_18: got src=%h en=%b xpt=%0d req=%b want 18/1/0/0", Source, enable, XPT, mem.Mem_Req); end
        repeat (2) tick();
        P2_Set_CMR = 1'b1;
        tick();
        P2_Set_CMR = 1'b0;
        checks++; if (mem.Mem_Req !== 1'b1 || mem.Mem_M1 !== 1'b0 || enable !== 1'b0 || XPT !== 5'd2) begin errors++; $display("FAIL cmr_to_read: got req=%b m1=%b en=%b xpt=%0d want 1/0/0/2", mem.Mem_Req, mem.Mem_M1, enable, XPT); end
        P2_Set_CM1 = 1'b1;
        PR_Reset_XPT = 1'b1;
        P2_Set_CMR = 1'b1;
        repeat (2) tick();
        P2_Set_CM1 = 1'b0;
        PR_Reset_XPT = 1'b0;
        P2_Set_CMR = 1'b0;
        checks++; if (mem.Mem_M1 !== 1'b0 || enable !== 1'b0 || XPT !== 5'd2) begin errors++; $display("FAIL read_ignores_strobes: got m1=%b en=%b xpt=%0d want 0/0/2", mem.Mem_M1, enable, XPT); end
        mem.Mem_Ready = 1'b1;
        mem.Mem_Data = 8'hFE;
        tick();
        mem.Mem_Ready = 1'b0;
        checks++; if (Operand !== 8'hFE || enable !== 1'b1 || XPT !== 5'd3) begin errors++; $display("FAIL read_fe: got op=%h en=%b xpt=%0d want fe/1/3", Operand, enable, XPT); end
    endtask

    task automatic test_all_strobes();
        P2_Set_CM1 = 1'b1;
        P2_Set_CMR = 1'b1;
        PR_Reset_XPT = 1'b1;
        tick();
        P2_Set_CM1 = 1'b0;
        P2_Set_CMR = 1'b0;
        PR_Reset_XPT = 1'b0;
        checks++; if (mem.Mem_M1 !== 1'b1 || mem.Mem_Req !== 1'b1 || enable !== 1'b0 || XPT !== 5'd0) begin errors++; $display("FAIL all_strobes: got m1=%b req=%b en=%b xpt=%0d want 1/1/0/0", mem.Mem_M1, mem.Mem_Req, enable, XPT); end
        mem.Mem_Ready = 1'b1;
        mem.Mem_Data = 8'($urandom);
        tick();
        mem.Mem_Ready = 1'b0;
        checks++; if (Source !== m_src || notSource !== ~m_src) begin errors++; $display("FAIL rand_fetch: got %h want %h", Source, m_src); end
    endtask

    task automatic test_pr_reset();
        repeat (7) tick();
        checks++; if (XPT !== 5'd7) begin errors++; $display("FAIL xpt_at_7: got %0d want 7", XPT); end
        PR_Reset_XPT = 1'b1;
        tick();
        PR_Reset_XPT = 1'b0;
        checks++; if (XPT !== 5'd0 || enable !== 1'b1 || mem.Mem_Req !== 1'b0) begin errors++; $display("FAIL pr_reset: got xpt=%0d en=%b req=%b want 0/1/0", XPT, enable, mem.Mem_Req); end
    endtask

    task automatic test_reset_in_read();
        P2_Set_CMR = 1'b1;
        tick();
        P2_Set_CMR = 1'b0;
        mem.Mem_Ready = 1'b0;
        tick();
        notReset = 1'b0;
        mem.Mem_Ready = 1'b1;
        mem.Mem_Data = 8'h77;
        tick();
        checks++; if (mem.Mem_Req !== 1'b0 || mem.Mem_M1 !== 1'b0 || enable !== 1'b0 || XPT !== 5'd0 || notXPT !== 5'h1F
                     || Source !== 8'h00 || notSource !== 8'hFF || Operand !== 8'h00 || Bus_Timeout !== 1'b0) begin
            errors++; $display("FAIL reset_in_read: got req=%b m1=%b en=%b xpt=%0d src=%h op=%h to=%b want all reset", mem.Mem_Req, mem.Mem_M1, enable, XPT, Source, Operand, Bus_Timeout);
        end
        notReset = 1'b1;
        mem.Mem_Ready = 1'b0;
        tick();
        checks++; if (mem.Mem_Req !== 1'b1 || mem.Mem_M1 !== 1'b1) begin errors++; $display("FAIL refetch_after_reset: got req=%b m1=%b want 1/1", mem.Mem_Req, mem.Mem_M1); end
    endtask

    task automatic test_timeout();
        int drops;
        mem.Mem_Ready = 1'b1;
        mem.Mem_Data = 8'h5A;
        tick();
        mem.Mem_Ready = 1'b0;
        P2_Set_CM1 = 1'b1;
        tick();
        P2_Set_CM1 = 1'b0;
`ifdef SEQ_WAIT_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (mem.Mem_Req !== 1'b1 || Bus_Timeout !== 1'b0) begin errors++; $display("FAIL to_waiting: got req=%b to=%b want 1/0", mem.Mem_Req, Bus_Timeout); end
        end
        tick();
        checks++; if (enable !== 1'b1 || Source !== 8'h00 || Bus_Timeout !== 1'b1) begin errors++; $display("FAIL to_abort: got en=%b src=%h to=%b want 1/00/1", enable, Source, Bus_Timeout); end
        P2_Set_CM1 = 1'b1;
        tick();
        P2_Set_CM1 = 1'b0;
        mem.Mem_Ready = 1'b1;
        mem.Mem_Data = 8'h33;
        tick();
        mem.Mem_Ready = 1'b0;
        checks++; if (Bus_Timeout !== 1'b1 || Source !== 8'h33) begin errors++; $display("FAIL to_sticky: got to=%b src=%h want 1/33", Bus_Timeout, Source); end
`else
        drops = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (mem.Mem_Req !== 1'b1 || Bus_Timeout !== 1'b0 || enable !== 1'b0) drops++;
        end
        checks++; if (drops != 0) begin errors++; $display("FAIL no_timeout: got %0d bad cycles want 0", drops); end
        mem.Mem_Ready = 1'b1;
        mem.Mem_Data = 8'hC3;
        tick();
        mem.Mem_Ready = 1'b0;
        checks++; if (Source !== 8'hC3 || enable !== 1'b1) begin errors++; $display("FAIL late_fetch: got src=%h en=%b want c3/1", Source, enable); end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            notReset      = ($urandom_range(0, 99) != 0);
            mem.Mem_Ready = ($urandom_range(0, 2) == 0);
            mem.Mem_Data  = 8'($urandom);
            P2_Set_CM1    = ($urandom_range(0, 7) == 0);
            P2_Set_CMR    = ($urandom_range(0, 5) == 0);
            PR_Reset_XPT  = ($urandom_range(0, 9) == 0);
            tick();
            checks++;
            if (mem.Mem_Req !== m_req || mem.Mem_M1 !== m_m1 || enable !== (m_phase == 1) || XPT !== 5'(m_xpt) || notXPT !== ~5'(m_xpt)
                || Source !== m_src || notSource !== ~m_src || Operand !== m_op || Bus_Timeout !== m_to) begin
                errors++;
                $display("FAIL random[%0d]: got req=%b m1=%b en=%b xpt=%0d src=%h op=%h to=%b want req=%b m1=%b en=%b xpt=%0d src=%h op=%h to=%b",
                         i, mem.Mem_Req, mem.Mem_M1, enable, XPT, Source, Operand, Bus_Timeout,
                         m_req, m_m1, (m_phase == 1), m_xpt, m_src, m_op, m_to);
            end
        end
        notReset = 1'b1;
        P2_Set_CM1 = 1'b0;
        P2_Set_CMR = 1'b0;
        PR_Reset_XPT = 1'b0;
    endtask

    initial begin
        mem.Mem_Ready = 1'b0;
        mem.Mem_Data = 8'h00;
        test_reset();
        test_zero_wait_count();
        test_wait_fetch_read();
        test_all_strobes();
        test_pr_reset();
        test_reset_in_read();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
